// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encodings, controller states and phase-duration lookup
package traffic_pkg;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} lamp_t;
  typedef enum logic [2:0] {AG, AY, RED1, WALKS, BG, BY, RED2} state_t;
  function automatic int unsigned dur(state_t s, int unsigned ga, int unsigned gb,
                                      int unsigned y, int unsigned r, int unsigned w);
    return (s == AG) ? ga : (s == BG) ? gb : (s == AY || s == BY) ? y : (s == WALKS) ? w : r;
  endfunction
endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that parks at zero
module phase_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= RST_VAL;
    else if (load) count_q <= load_val;
    else if (!done) count_q <= count_q - 1'b1;
  assign done  = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-road plus pedestrian light sequencer with demand latches and safety monitors
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_A = 40,
  parameter int GREEN_B = 20,
  parameter int YELLOW_T = 5,
  parameter int ALL_RED = 2,
  parameter int WALK_T = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_b,
  input  logic             ped_req,
  output logic [1:0]       light_a,
  output logic [1:0]       light_b,
  output logic             walk,
  output logic [CNT_W-1:0] time_left,
  output logic             p1,
  output logic             p2,
  output logic             p3
);
  state_t state_q, state_d;
  logic car_pend_q, car_pend_d, ped_pend_q, ped_pend_d;
  logic done, load;
  logic [CNT_W-1:0] count, load_val;
  function automatic int unsigned d(state_t s);
    return dur(s, GREEN_A, GREEN_B, YELLOW_T, ALL_RED, WALK_T);
  endfunction
  phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(ALL_RED - 1))) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .done(done), .count(count)
  );
  always_comb begin
    state_d = state_q;
    if (done)
      case (state_q)
        AG:      state_d = (car_pend_q || ped_pend_q) ? AY : AG;
        AY:      state_d = RED1;
        RED1:    state_d = ped_pend_q ? WALKS : BG;
        WALKS:   state_d = car_pend_q ? BG : AG;
        BG:      state_d = BY;
        BY:      state_d = RED2;
        default: state_d = AG;
      endcase
  end
  // AG holding at zero is the only case where done does not change state
  assign load     = state_d != state_q;
  assign load_val = CNT_W'(d(state_d) - 1);
  // entering the serving phase clears the latch even if a new request arrives that cycle
  assign car_pend_d = (state_d == BG && state_q != BG) ? 1'b0 :
                      (car_b && state_q != BG) ? 1'b1 : car_pend_q;
  assign ped_pend_d = (state_d == WALKS && state_q != WALKS) ? 1'b0 :
                      (ped_req && state_q != WALKS) ? 1'b1 : ped_pend_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= RED2;
      car_pend_q <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      car_pend_q <= car_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  assign light_a   = state_q == AG ? GREEN : state_q == AY ? YELLOW : RED;
  assign light_b   = state_q == BG ? GREEN : state_q == BY ? YELLOW : RED;
  assign walk      = state_q == WALKS;
  assign time_left = count;
  assign p1 = light_a != RED && light_b != RED;
  assign p2 = walk && (light_a != RED || light_b != RED);
  assign p3 = 32'(count) > d(state_q) - 1;
endmodule
